// File: rtl/oh_pwr_ctrl.sv
// oh_pwr_ctrl: power-domain sequencer for an oh_pwr_gate header switch.
// Drives npower, isolation, retention save/restore and domain reset
// around each gating event. A level request/ack handshake faces the
// system controller. Both sequences are fixed and cannot be aborted
// except by nreset.
module oh_pwr_ctrl #(
   parameter int RAMP_CYCLES = 16,
   parameter int RST_CYCLES  = 4,
   parameter int ISO_CYCLES  = 2,
   parameter int CW          = 8
) (
   input  logic clk,
   input  logic nreset,
   input  logic pwr_on_req,
   output logic pwr_on_ack,
   output logic busy,
   output logic npower,
   output logic iso,
   output logic save,
   output logic restore,
   output logic domain_nreset
);

   typedef enum logic [2:0] {
      OFF,
      RAMP,
      RSTREL,
      RESTORE,
      ON,
      ISO,
      SAVE,
      RSTASSERT
   } state_t;

   // Dwell reload values: a state lasting P cycles starts its counter at P-1.
   localparam logic [CW-1:0] RAMP_LD = CW'(RAMP_CYCLES - 1);
   localparam logic [CW-1:0] RST_LD  = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] ISO_LD  = CW'(ISO_CYCLES - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          cnt_zero;

   assign cnt_zero = (cnt == '0);

   // Output pattern of each state, packed as
   // {npower, iso, domain_nreset, save, restore, pwr_on_ack, busy}.
   function automatic logic [6:0] outs(input state_t s);
      logic [6:0] v;
      v = 7'b1100000;
      case (s)
         OFF:       v = 7'b1100000;
         RAMP:      v = 7'b0100001;
         RSTREL:    v = 7'b0110001;
         RESTORE:   v = 7'b0110101;
         ON:        v = 7'b0010010;
         ISO:       v = 7'b0110001;
         SAVE:      v = 7'b0111001;
         RSTASSERT: v = 7'b0100001;
         default:   v = 7'b1100000;
      endcase
      return v;
   endfunction

   // Sequencer: state, dwell counter and registered outputs, all updated
   // on the edge that enters a state so outputs never depend on inputs
   // combinationally.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state <= OFF;
         cnt   <= '0;
         {npower, iso, domain_nreset, save, restore, pwr_on_ack, busy} <= outs(OFF);
      end else begin
         case (state)
            OFF: begin
               if (pwr_on_req) begin
                  state <= RAMP;
                  cnt   <= RAMP_LD;
                  {npower, iso, domain_nreset, save, restore, pwr_on_ack, busy} <= outs(RAMP);
               end
            end
            RAMP: begin
               if (cnt_zero) begin
                  state <= RSTREL;
                  cnt   <= RST_LD;
                  {npower, iso, domain_nreset, save, restore, pwr_on_ack, busy} <= outs(RSTREL);
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RSTREL: begin
               if (cnt_zero) begin
                  state <= RESTORE;
                  {npower, iso, domain_nreset, save, restore, pwr_on_ack, busy} <= outs(RESTORE);
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RESTORE: begin
               state <= ON;
               {npower, iso, domain_nreset, save, restore, pwr_on_ack, busy} <= outs(ON);
            end
            ON: begin
               if (!pwr_on_req) begin
                  state <= ISO;
                  cnt   <= ISO_LD;
                  {npower, iso, domain_nreset, save, restore, pwr_on_ack, busy} <= outs(ISO);
               end
            end
            ISO: begin
               if (cnt_zero) begin
                  state <= SAVE;
                  {npower, iso, domain_nreset, save, restore, pwr_on_ack, busy} <= outs(SAVE);
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            SAVE: begin
               state <= RSTASSERT;
               cnt   <= RST_LD;
               {npower, iso, domain_nreset, save, restore, pwr_on_ack, busy} <= outs(RSTASSERT);
            end
            RSTASSERT: begin
               if (cnt_zero) begin
                  state <= OFF;
                  {npower, iso, domain_nreset, save, restore, pwr_on_ack, busy} <= outs(OFF);
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state <= OFF;
               cnt   <= '0;
               {npower, iso, domain_nreset, save, restore, pwr_on_ack, busy} <= outs(OFF);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_oh_pwr_ctrl.sv
// Testbench for oh_pwr_ctrl with short dwell parameters.
module tb_oh_pwr_ctrl;

   localparam int RAMP = 4;
   localparam int RSTC = 2;
   localparam int ISOC = 3;

   logic clk;
   logic nreset;
   logic pwr_on_req;
   logic pwr_on_ack;
   logic busy;
   logic npower;
   logic iso;
   logic save;
   logic restore;
   logic domain_nreset;

   int checks = 0;
   int errors = 0;

   logic [6:0] exp_q[$];
   logic [6:0] obs;

   typedef enum int {M_OFF, M_UP, M_ON, M_DN} mode_t;
   mode_t m_mode = M_OFF;
   int    m_t    = 0;

   assign obs = {npower, iso, domain_nreset, save, restore, pwr_on_ack, busy};

   oh_pwr_ctrl #(
      .RAMP_CYCLES(RAMP),
      .RST_CYCLES (RSTC),
      .ISO_CYCLES (ISOC),
      .CW         (8)
   ) dut (
      .clk          (clk),
      .nreset       (nreset),
      .pwr_on_req   (pwr_on_req),
      .pwr_on_ack   (pwr_on_ack),
      .busy         (busy),
      .npower       (npower),
      .iso          (iso),
      .save         (save),
      .restore      (restore),
      .domain_nreset(domain_nreset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {npower, iso, domain_nreset, save, restore, ack, busy} from
   // the time elapsed since the current sequence began.
   function automatic logic [6:0] model_vec(input mode_t m, input int t);
      logic [6:0] v;
      v = 7'b1100000;
      case (m)
         M_OFF: v = 7'b1100000;
         M_ON:  v = 7'b0010010;
         M_UP: begin
            if (t < RAMP)             v = 7'b0100001;
            else if (t < RAMP + RSTC) v = 7'b0110001;
            else                      v = 7'b0110101;
         end
         M_DN: begin
            if (t < ISOC)       v = 7'b0110001;
            else if (t == ISOC) v = 7'b0111001;
            else                v = 7'b0100001;
         end
         default: v = 7'b1100000;
      endcase
      return v;
   endfunction

   // Drive one cycle of stimulus, push the expected outputs, sample #1 after the edge.
   task automatic tick(input logic rst_n, input logic req);
      nreset     = rst_n;
      pwr_on_req = req;
      if (!rst_n) begin
         m_mode = M_OFF;
         m_t    = 0;
      end else begin
         case (m_mode)
            M_OFF: if (req) begin m_mode = M_UP; m_t = 0; end
            M_UP: begin
               m_t++;
               if (m_t == RAMP + RSTC + 1) m_mode = M_ON;
            end
            M_ON: if (!req) begin m_mode = M_DN; m_t = 0; end
            M_DN: begin
               m_t++;
               if (m_t == ISOC + 1 + RSTC) m_mode = M_OFF;
            end
            default: m_mode = M_OFF;
         endcase
      end
      exp_q.push_back(model_vec(m_mode, m_t));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] e;
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, 1'b1);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset cyc %0d got %b exp %b", k, obs, e);
         end
         checks++;
         if (obs !== 7'b1100000) begin
            errors++;
            $display("FAIL reset_vals cyc %0d got %b exp 1100000", k, obs);
         end
      end
   endtask

   task automatic test_power_up();
      logic [6:0] e;
      for (int k = 0; k <= 8; k++) begin
         tick(1'b1, 1'b1);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL power_up cyc %0d got %b exp %b", k, obs, e);
         end
         if (k == 0) begin
            checks++;
            if (npower !== 1'b0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL up_e0 npower=%b busy=%b exp 0 1", npower, busy);
            end
         end
         if (k == 4) begin
            checks++;
            if (domain_nreset !== 1'b1) begin
               errors++;
               $display("FAIL up_dnr_rise got %b exp 1", domain_nreset);
            end
         end
         checks++;
         if (restore !== (k == 6)) begin
            errors++;
            $display("FAIL up_restore cyc %0d got %b exp %b", k, restore, (k == 6));
         end
         if (k == 7) begin
            checks++;
            if (iso !== 1'b0 || pwr_on_ack !== 1'b1 || busy !== 1'b0) begin
               errors++;
               $display("FAIL up_on iso=%b ack=%b busy=%b exp 0 1 0", iso, pwr_on_ack, busy);
            end
         end
      end
   endtask

   task automatic test_power_down();
      logic [6:0] e;
      for (int k = 0; k <= 7; k++) begin
         tick(1'b1, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL power_down cyc %0d got %b exp %b", k, obs, e);
         end
         if (k == 0) begin
            checks++;
            if (iso !== 1'b1 || pwr_on_ack !== 1'b0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL dn_f0 iso=%b ack=%b busy=%b exp 1 0 1", iso, pwr_on_ack, busy);
            end
         end
         checks++;
         if (save !== (k == 3)) begin
            errors++;
            $display("FAIL dn_save cyc %0d got %b exp %b", k, save, (k == 3));
         end
         if (k == 4) begin
            checks++;
            if (domain_nreset !== 1'b0) begin
               errors++;
               $display("FAIL dn_dnr_fall got %b exp 0", domain_nreset);
            end
         end
         if (k == 6) begin
            checks++;
            if (npower !== 1'b1 || busy !== 1'b0) begin
               errors++;
               $display("FAIL dn_off npower=%b busy=%b exp 1 0", npower, busy);
            end
         end
      end
   endtask

   task automatic test_glitch();
      logic [6:0] e;
      int acks;
      acks = 0;
      for (int k = 0; k <= 16; k++) begin
         tick(1'b1, (k < 2));
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL glitch cyc %0d got %b exp %b", k, obs, e);
         end
         if (pwr_on_ack === 1'b1) acks++;
         if (k == 7) begin
            checks++;
            if (pwr_on_ack !== 1'b1) begin
               errors++;
               $display("FAIL glitch_ack got %b exp 1", pwr_on_ack);
            end
         end
         if (k == 8) begin
            checks++;
            if (iso !== 1'b1 || pwr_on_ack !== 1'b0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL glitch_dn_start iso=%b ack=%b busy=%b exp 1 0 1", iso, pwr_on_ack, busy);
            end
         end
         if (k == 14) begin
            checks++;
            if (npower !== 1'b1 || busy !== 1'b0) begin
               errors++;
               $display("FAIL glitch_off npower=%b busy=%b exp 1 0", npower, busy);
            end
         end
      end
      checks++;
      if (acks != 1) begin
         errors++;
         $display("FAIL glitch_ack_len got %0d cycles exp 1", acks);
      end
   endtask

   task automatic test_reset_mid_save();
      logic [6:0] e;
      bit found;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick(1'b1, 1'b1);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL rsave_up cyc %0d got %b exp %b", k, obs, e);
         end
      end
      for (int k = 0; k < 20 && !found; k++) begin
         tick(1'b1, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL rsave_dn cyc %0d got %b exp %b", k, obs, e);
         end
         if (save === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL rsave_wait got no save pulse exp one within 20 cycles");
      end
      tick(1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL rsave_rst got %b exp %b", obs, e);
      end
      checks++;
      if (npower !== 1'b1 || iso !== 1'b1 || domain_nreset !== 1'b0 || save !== 1'b0) begin
         errors++;
         $display("FAIL rsave_abrupt got %b exp 1100000", obs);
      end
      for (int k = 0; k < 10; k++) begin
         tick(1'b1, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL rsave_after cyc %0d got %b exp %b", k, obs, e);
         end
         checks++;
         if (save !== 1'b0 || restore !== 1'b0 || npower !== 1'b1) begin
            errors++;
            $display("FAIL rsave_quiet cyc %0d save=%b restore=%b npower=%b exp 0 0 1", k, save, restore, npower);
         end
      end
   endtask

   task automatic test_random();
      logic [6:0] e;
      logic req;
      logic prev_save;
      logic prev_restore;
      req          = 1'b0;
      prev_save    = 1'b0;
      prev_restore = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 5) == 0) req = ~req;
         tick(1'b1, req);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL random cyc %0d got %b exp %b", i, obs, e);
         end
         checks++;
         if ((npower === 1'b1 || domain_nreset === 1'b0) && iso !== 1'b1) begin
            errors++;
            $display("FAIL inv_iso cyc %0d iso=%b npower=%b dnr=%b exp iso 1", i, iso, npower, domain_nreset);
         end
         checks++;
         if (save === 1'b1 && restore === 1'b1) begin
            errors++;
            $display("FAIL inv_excl cyc %0d save=%b restore=%b exp not both", i, save, restore);
         end
         checks++;
         if ((save === 1'b1 && prev_save === 1'b1) || (restore === 1'b1 && prev_restore === 1'b1)) begin
            errors++;
            $display("FAIL inv_pulse cyc %0d save=%b restore=%b exp 1-cycle pulses", i, save, restore);
         end
         prev_save    = save;
         prev_restore = restore;
      end
   endtask

   initial begin
      nreset     = 1'b0;
      pwr_on_req = 1'b1;
      test_reset();
      test_power_up();
      test_power_down();
      test_glitch();
      test_reset_mid_save();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
